// File: rtl/evt_counter_bank.sv
// Multi-channel event counter bank: per-channel wrap/saturate counters with sticky
// overflow, terminal-count pulse, coherent global snapshot and a 1-cycle read port.
module evt_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_CH-1:0]         evt_in,
  input  logic [NUM_CH-1:0]         en_in,
  input  logic [NUM_CH-1:0]         clr_in,
  input  logic                      sat_mode_in,
  input  logic [WIDTH-1:0]          limit_in,
  input  logic                      snap_in,
  input  logic                      rd_req_in,
  input  logic [SEL_W-1:0]          rd_sel_in,
  output logic [NUM_CH*WIDTH-1:0]   count_out,
  output logic [NUM_CH-1:0]         ovf_out,
  output logic [NUM_CH-1:0]         tc_pulse_out,
  output logic                      rd_valid_out,
  output logic [WIDTH-1:0]          rd_count_out,
  output logic                      rd_ovf_out
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0][WIDTH-1:0] count_r;
  logic [NUM_CH-1:0]            ovf_r;
  logic [NUM_CH-1:0]            tc_r;
  logic [NUM_CH-1:0][WIDTH-1:0] snap_count_r;
  logic [NUM_CH-1:0]            snap_ovf_r;
  logic                         rd_valid_r;
  logic [WIDTH-1:0]             rd_count_r;
  logic                         rd_ovf_r;

  logic [NUM_CH-1:0][WIDTH-1:0] next_count_s;
  logic [NUM_CH-1:0]            next_ovf_s;
  logic [NUM_CH-1:0]            tc_set_s;
  logic                         rd_in_range_s;

  assign rd_in_range_s = (32'(rd_sel_in) < NUM_CH);

  // Per-channel next state: clear beats an accepted event; terminal events wrap or saturate.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      next_count_s[i] = count_r[i];
      next_ovf_s[i]   = ovf_r[i];
      tc_set_s[i]     = 1'b0;
      if (clr_in[i]) begin
        next_count_s[i] = ZERO_C;
        next_ovf_s[i]   = 1'b0;
      end else if (evt_in[i] && en_in[i]) begin
        if (count_r[i] < limit_in) begin
          next_count_s[i] = count_r[i] + ONE_C;
        end else begin
          next_ovf_s[i] = 1'b1;
          if (sat_mode_in) begin
            next_count_s[i] = limit_in;
          end else begin
            next_count_s[i] = ZERO_C;
          end
        end
        // A held saturated count does not change, so it cannot re-pulse.
        tc_set_s[i] = (next_count_s[i] != count_r[i]) && (next_count_s[i] == limit_in);
      end else begin
        next_count_s[i] = count_r[i];
      end
    end
  end

  // Live counters, flags and snapshot; snapshot samples pre-update values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_r      <= '0;
      ovf_r        <= '0;
      tc_r         <= '0;
      snap_count_r <= '0;
      snap_ovf_r   <= '0;
    end else begin
      count_r <= next_count_s;
      ovf_r   <= next_ovf_s;
      tc_r    <= tc_set_s;
      if (snap_in) begin
        snap_count_r <= count_r;
        snap_ovf_r   <= ovf_r;
      end else begin
        snap_count_r <= snap_count_r;
        snap_ovf_r   <= snap_ovf_r;
      end
    end
  end

  // Read port: reads the snapshot as it stood before this edge; data holds when idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_valid_r <= 1'b0;
      rd_count_r <= ZERO_C;
      rd_ovf_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_req_in;
      if (rd_req_in) begin
        if (rd_in_range_s) begin
          rd_count_r <= snap_count_r[rd_sel_in];
          rd_ovf_r   <= snap_ovf_r[rd_sel_in];
        end else begin
          rd_count_r <= ZERO_C;
          rd_ovf_r   <= 1'b0;
        end
      end else begin
        rd_count_r <= rd_count_r;
        rd_ovf_r   <= rd_ovf_r;
      end
    end
  end

  assign count_out    = count_r;
  assign ovf_out      = ovf_r;
  assign tc_pulse_out = tc_r;
  assign rd_valid_out = rd_valid_r;
  assign rd_count_out = rd_count_r;
  assign rd_ovf_out   = rd_ovf_r;

endmodule

// File: doc/evt_counter_bank.md
# evt_counter_bank

Multi-channel event counter bank for the on-chip debugger. It gives NUM_CH independent counters, each with a runtime terminal count, wrap or saturate mode, a sticky overflow flag, per-channel clear and a terminal-count pulse. A global snapshot freezes every channel at the same instant. A one-cycle-latency read port then returns the frozen values to the debugger readout logic.

## Interface
Parameters:
- NUM_CH, 4, number of channels (≥2)
- WIDTH, 16, counter width in bits (≥2)

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous reset, active-high
- evt_in  input  NUM_CH  per-channel event strobe, one count per high cycle
- en_in  input  NUM_CH  per-channel count enable; an event counts only if en_in[i]=1
- clr_in  input  NUM_CH  per-channel synchronous clear
- sat_mode_in  input  1  0 = wrap, 1 = saturate; applies to all channels
- limit_in  input  WIDTH  terminal count, shared by all channels
- snap_in  input  1  capture all live counts and flags into snapshot registers
- rd_req_in  input  1  read request
- rd_sel_in  input  $clog2(NUM_CH)  channel to read
- count_out  output  NUM_CH*WIDTH  live counts; channel i is at bits [i*WIDTH +: WIDTH]
- ovf_out  output  NUM_CH  sticky overflow flags, live
- tc_pulse_out  output  NUM_CH  one-cycle terminal-count pulse
- rd_valid_out  output  1  read data valid
- rd_count_out  output  WIDTH  snapshot count of the selected channel
- rd_ovf_out  output  1  snapshot overflow flag of the selected channel

## Operation
- An event is accepted for channel i when evt_in[i] & en_in[i].
- Per-channel priority, highest first:
  - rst_in
  - clr_in[i]: count ← 0, ovf ← 0
  - accepted event
  - hold
- Accepted event with count < limit_in: count ← count+1.
- Accepted event with count ≥ limit_in (terminal):
  - Wrap mode: count ← 0.
  - Saturate mode: count ← limit_in.
  - In both modes ovf[i] ← 1.
- Lowering limit_in below the current count is legal. The next accepted event treats the channel as terminal.
- limit_in = 0: every accepted event sets ovf; the count stays 0.
- tc_pulse_out[i] is high for exactly one cycle, the cycle after an edge where count changed to a value equal to limit_in.
  - No pulse while a saturated count is held.
  - No pulse if clr_in[i] wins that edge.
- Snapshot: snap_in=1 copies every live count and ovf, as they were before that edge's update, into snap_count[i] and snap_ovf[i].
  - An event or clear on the same edge does not affect the captured value.
  - Snapshot registers are not changed by clr_in.
- Read: rd_req_in=1 registers rd_valid_out=1 for the next cycle, with rd_count_out = snap_count[rd_sel_in] and rd_ovf_out = snap_ovf[rd_sel_in].
  - The read uses snapshot contents from before the same-edge snap_in, so a simultaneous snap and read returns old data.
  - rd_sel_in ≥ NUM_CH returns rd_count_out=0 and rd_ovf_out=0, and rd_valid_out still asserts.
  - With rd_req_in=0, rd_valid_out=0 and the rd data outputs hold their last values.
- Arithmetic is unsigned WIDTH bits. count+1 never exceeds limit_in ≤ 2^WIDTH−1, so no carry-out is needed.

## Timing
- Reset values: all counts 0, ovf_out 0, tc_pulse_out 0, snapshot registers 0, rd_valid_out 0, rd_count_out 0, rd_ovf_out 0.
- Reset mid-operation clears everything on the next edge, including any read in flight: rd_valid_out=0 the cycle after.
- count_out and ovf_out are registered: a change is visible 1 cycle after the accepting edge.
- tc_pulse_out rises on the same edge the count reaches limit_in.
- Read latency is 1 cycle from rd_req_in to rd_valid_out. rd_req_in may be high every cycle, giving one result per cycle.
- All channels update in parallel with no cross-channel interaction.

## Test plan
- Wrap, single channel: limit_in=3, sat_mode_in=0, 5 accepted events on ch0.
  - count_out[ch0] goes 1,2,3,0,1.
  - tc_pulse once, after the 3rd event.
  - ovf set after the 4th event.
  - Other channels stay 0.
- Saturate: limit_in=2, sat_mode_in=1, 4 events on ch1.
  - Count goes 1,2,2,2.
  - Exactly one tc_pulse.
  - ovf=1 after the 3rd event.
  - clr_in[1] then gives count=0 and ovf=0.
- Priority and enable:
  - evt_in[2]=1 with en_in[2]=0 for 3 cycles: count stays 0.
  - evt_in and clr_in high together on a channel at count 5: count=0, no tc_pulse.
- Snapshot coherence: ch0=7 and ch3=9; pulse snap_in while ch0 receives an event.
  - Reads of ch0 and ch3 return 7 and 9, not 8.
  - Read returns ovf as captured.
- Read edge cases:
  - snap_in and rd_req_in on the same cycle: returns the previous snapshot.
  - rd_sel_in=NUM_CH (when NUM_CH is not a power of two): rd_valid_out=1, data 0.
  - Back-to-back reads on ch0, ch1, ch2: three consecutive valid cycles.
- Limit change and reset:
  - Count 10 with limit_in changed to 4, then one event: wrap gives 0 with ovf=1; saturate gives 4.
  - rst_in asserted mid-read: all outputs 0 on the next cycle.
